// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQ requesters.
// One transfer outstanding at a time, with a BUSY timeout that aborts the engine.
module dma_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        req_wr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic                      dma_start,
    output logic [ADDR_W-1:0]         dma_addr,
    output logic [LEN_W-1:0]          dma_len,
    output logic                      dma_wr,
    input  logic                      dma_done,
    output logic                      dma_abort,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt, win, win_nxt, scan_idx;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 found;
    logic [NUM_REQ-1:0]   grant_nxt, done_nxt, err_nxt;
    logic                 start_nxt, abort_nxt, busy_nxt, wr_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [LEN_W-1:0]     len_nxt;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
    endfunction

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr) + k)]) begin
                found    = 1'b1;
                scan_idx = wrap_idx(int'(ptr) + k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        addr_nxt  = dma_addr;
        len_nxt   = dma_len;
        wr_nxt    = dma_wr;
        start_nxt = 1'b0;
        done_nxt  = '0;
        err_nxt   = '0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = ISSUE;
                    win_nxt   = scan_idx;
                    grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << scan_idx;
                    addr_nxt  = req_addr[scan_idx*ADDR_W +: ADDR_W];
                    len_nxt   = req_len[scan_idx*LEN_W +: LEN_W];
                    wr_nxt    = req_wr[scan_idx];
                end
            end
            ISSUE: begin
                start_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = BUSY;
            end
            BUSY: begin
                cnt_nxt = cnt + 1'b1;
                // A completion on the final cycle beats the timeout.
                if (dma_done) begin
                    done_nxt  = grant;
                    state_nxt = RELEASE;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    done_nxt  = grant;
                    err_nxt   = grant;
                    abort_nxt = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                grant_nxt = '0;
                ptr_nxt   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            grant     <= '0;
            req_done  <= '0;
            req_err   <= '0;
            dma_start <= 1'b0;
            dma_addr  <= '0;
            dma_len   <= '0;
            dma_wr    <= 1'b0;
            dma_abort <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            req_done  <= done_nxt;
            req_err   <= err_nxt;
            dma_start <= start_nxt;
            dma_addr  <= addr_nxt;
            dma_len   <= len_nxt;
            dma_wr    <= wr_nxt;
            dma_abort <= abort_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: the driver pushes predicted start/done records,
// a negedge monitor pops and compares them whenever the DUT pulses dma_start or req_done.
module tb_dma_arbiter;

    localparam int N       = 3;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_addr;
    logic [N*16-1:0] req_len;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    grant, req_done, req_err;
    logic            dma_start, dma_wr, dma_done, dma_abort, busy;
    logic [31:0]     dma_addr;
    logic [15:0]     dma_len;

    dma_arbiter #(.NUM_REQ(N), .ADDR_W(32), .LEN_W(16), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_wr(req_wr), .grant(grant), .req_done(req_done), .req_err(req_err),
        .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len), .dma_wr(dma_wr),
        .dma_done(dma_done), .dma_abort(dma_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [31:0]  addr;
        logic [15:0]  len;
        logic         wr;
    } start_rec_t;

    typedef struct {
        logic [N-1:0] done;
        logic         err;
        int           lat;
        logic [31:0]  addr;
        logic [15:0]  len;
        logic         wr;
    } done_rec_t;

    start_rec_t start_q[$];
    done_rec_t  done_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         model_ptr = 0;

    task automatic check_output(input bit ok, input string name, input string detail);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++)
            if (rq[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    int         cyc = 0;
    int         start_cyc = 0;
    int         grant_age = 0;
    start_rec_t m_s;
    done_rec_t  m_d;

    always @(negedge clk) begin
        if (reset) begin
            grant_age = 0;
        end else begin
            cyc++;
            if (grant == '0) grant_age = 0;
            else grant_age++;
            check_output(busy == (grant != '0) && $onehot0(grant) && $onehot0(req_done) &&
                         $onehot0(req_err) && ((req_err & ~req_done) == '0) &&
                         (dma_abort == (req_err != '0)), "invariants",
                         $sformatf("busy=%b grant=%b done=%b err=%b abort=%b", busy, grant, req_done, req_err, dma_abort));
            if (dma_start) begin
                start_cyc = cyc;
                if (start_q.size() == 0) begin
                    check_output(1'b0, "unexpected_start", $sformatf("grant=%b", grant));
                end else begin
                    m_s = start_q.pop_front();
                    check_output(grant == m_s.grant && dma_addr == m_s.addr && dma_len == m_s.len &&
                                 dma_wr == m_s.wr && grant_age == 2, "start",
                                 $sformatf("got grant=%b addr=%h len=%0d wr=%b age=%0d, need grant=%b addr=%h len=%0d wr=%b age=2",
                                           grant, dma_addr, dma_len, dma_wr, grant_age, m_s.grant, m_s.addr, m_s.len, m_s.wr));
                end
            end
            if (req_done != '0) begin
                if (done_q.size() == 0) begin
                    check_output(1'b0, "unexpected_done", $sformatf("req_done=%b", req_done));
                end else begin
                    m_d = done_q.pop_front();
                    check_output(req_done == m_d.done && (req_err != '0) == m_d.err &&
                                 dma_abort == m_d.err && (cyc - start_cyc) == m_d.lat &&
                                 dma_addr == m_d.addr && dma_len == m_d.len && dma_wr == m_d.wr, "done",
                                 $sformatf("got done=%b err=%b abort=%b lat=%0d addr=%h, need done=%b err=%b lat=%0d addr=%h",
                                           req_done, req_err, dma_abort, cyc - start_cyc, dma_addr,
                                           m_d.done, m_d.err, m_d.lat, m_d.addr));
                end
            end
        end
    end

    // j = BUSY cycle that carries dma_done (0 = never, forcing the timeout path).
    task automatic apply_stimulus(input logic [N-1:0] rq, input int j, input bit corrupt,
                                  input bit drop, input bit rand_cmd);
        int         w;
        bit         seen;
        start_rec_t s;
        done_rec_t  d;
        if (rand_cmd) begin
            for (int i = 0; i < N; i++) begin
                req_addr[i*32 +: 32] = $urandom;
                req_len[i*16 +: 16]  = 16'($urandom);
                req_wr[i]            = 1'($urandom_range(0, 1));
            end
        end
        w         = pick(rq, model_ptr);
        model_ptr = (w + 1) % N;
        s.grant   = N'(1) << w;
        s.addr    = req_addr[w*32 +: 32];
        s.len     = req_len[w*16 +: 16];
        s.wr      = req_wr[w];
        start_q.push_back(s);
        req = rq;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dma_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_output(1'b0, "start_timeout", $sformatf("no dma_start for req=%b", rq));
            return;
        end
        d.done = s.grant;
        d.err  = (j == 0);
        d.lat  = (j == 0) ? TIMEOUT : j + 1;
        d.addr = s.addr;
        d.len  = s.len;
        d.wr   = s.wr;
        done_q.push_back(d);
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            dma_done = (c == j);
            if (drop && c == 1) req[w] = 1'b0;
            if (corrupt && c == 2) req_addr[w*32 +: 32] = 32'hDEAD;
            if (req_done != '0) begin
                seen = 1'b1;
                break;
            end
        end
        dma_done = 1'b0;
        if (!seen) check_output(1'b0, "done_timeout", $sformatf("no req_done for req=%b j=%0d", rq, j));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         jsel, jv;
        bit         saw;
        start_rec_t s;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        req_wr   = '0;
        dma_done = 1'b0;
        repeat (3) @(negedge clk);
        check_output({grant, req_done, req_err, dma_start, dma_addr, dma_len, dma_wr, dma_abort, busy} == '0,
                     "reset_state", $sformatf("grant=%b busy=%b start=%b addr=%h", grant, busy, dma_start, dma_addr));
        reset = 1'b0;
        model_ptr = 0;
        @(negedge clk);

        // Held 3'b111 rotates 001, 010, 100, 001.
        for (int i = 0; i < 4; i++) apply_stimulus(3'b111, 5, 1'b0, 1'b0, 1'b1);

        req_addr[1*32 +: 32] = 32'h1000;
        req_len[1*16 +: 16]  = 16'd256;
        req_wr[1]            = 1'b0;
        apply_stimulus(3'b010, 10, 1'b0, 1'b0, 1'b0);
        req = '0;
        repeat (3) @(negedge clk);
        check_output(busy == 1'b0 && grant == '0, "idle_after_release", $sformatf("busy=%b grant=%b, need 0", busy, grant));

        apply_stimulus(N'($urandom_range(1, 7)), 0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(N'($urandom_range(1, 7)), 7, 1'b0, 1'b0, 1'b1);
        apply_stimulus(N'($urandom_range(1, 7)), 15, 1'b0, 1'b0, 1'b1);
        apply_stimulus(N'($urandom_range(1, 7)), 12, 1'b1, 1'b0, 1'b1);
        apply_stimulus(N'($urandom_range(1, 7)), 6, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            jsel = $urandom_range(0, 9);
            jv   = (jsel == 0) ? 0 : (jsel == 1) ? 15 : $urandom_range(1, 14);
            apply_stimulus(N'($urandom_range(1, 7)), jv, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'b1);
        end
        req = '0;

        repeat (3) @(negedge clk);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req_done != '0 || busy) saw = 1'b1;
        end
        check_output(!saw, "stray_done_idle", $sformatf("saw done/busy=%b, need 0", saw));

        // Reset three cycles after dma_start drops everything with no completion.
        s.grant   = N'(1) << pick(3'b001, model_ptr);
        s.addr    = req_addr[31:0];
        s.len     = req_len[15:0];
        s.wr      = req_wr[0];
        start_q.push_back(s);
        req = 3'b001;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dma_start) begin
                saw = 1'b1;
                break;
            end
        end
        check_output(saw, "reset_test_start", "no dma_start before reset test");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output(grant == '0 && busy == 1'b0 && dma_start == 1'b0 && req_done == '0,
                     "reset_mid_busy", $sformatf("grant=%b busy=%b start=%b done=%b, need 0", grant, busy, dma_start, req_done));
        model_ptr = 0;
        req = 3'b100;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(3'b100, 4, 1'b0, 1'b0, 1'b1);
        req = '0;

        repeat (5) @(negedge clk);
        check_output(start_q.size() == 0 && done_q.size() == 0, "queues_drained",
                     $sformatf("start_q=%0d done_q=%0d, need 0", start_q.size(), done_q.size()));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
